image_row_feeder: RTL and testbench

Source side of the convolution memory bank's row-write interface. Collects a serial pixel stream into full image rows of IMAGE_SIZE elements, using two ping-pong assembly buffers. Presents each completed row as one packed word with a single-cycle wr_en, gated by the bank's ready. Tracks row position within a square frame and flags first and last rows.

---
 rtl/image_row_feeder.sv | 112 +++++++++++
 tb/tb_image_row_feeder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/image_row_feeder.sv
// image_row_feeder: gathers a serial pixel stream into full image rows using
// two ping-pong assembly buffers and hands each completed row to the memory
// bank as one packed word with a single-cycle wr_en. Tracks the row position
// inside a square frame and flags the first and last rows.
// Optional feature macro: FEEDER_PAD_EN -- when defined, flush zero-pads the
// partial row in the fill buffer and emits it as a normal row.
module image_row_feeder #(
  parameter int IMAGE_SIZE = 16,
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             pix_valid,
  input  logic [DATA_WIDTH-1:0]            pix_data,
  output logic                             pix_ready,
  input  logic                             flush,
  input  logic                             bank_ready,
  output logic                             wr_en,
  output logic [IMAGE_SIZE*DATA_WIDTH-1:0] data_out,
  output logic [IDX_WIDTH-1:0]             row_idx,
  output logic                             frame_start,
  output logic                             frame_done
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(IMAGE_SIZE - 1);

  logic [DATA_WIDTH-1:0]            row_buf [2][IMAGE_SIZE];
  logic [IDX_WIDTH-1:0]             col;
  logic [IDX_WIDTH-1:0]             row_cnt;
  logic [1:0]                       full;
  logic                             fill_sel;
  logic                             drain_sel;
  logic                             accept;
  logic                             pad_row;
  logic                             row_end;
  logic                             drain;
  logic [IMAGE_SIZE*DATA_WIDTH-1:0] drain_row;

  // Ready comes straight from registered flags so upstream sees no comb path.
  assign pix_ready = !full[fill_sel];
  assign accept    = pix_valid && pix_ready;

`ifdef FEEDER_PAD_EN
  assign pad_row = flush && (col != '0) && !full[fill_sel];
`else
  // flush has no function in this build; the partial row waits for pixels.
  assign pad_row = flush & 1'b0;
`endif

  assign row_end = (accept && (col == LAST_IDX)) || pad_row;
  assign drain   = full[drain_sel] && bank_ready;

  // Pack the buffer being drained into the bank's row word.
  always_comb begin
    drain_row = '0;
    for (int c = 0; c < IMAGE_SIZE; c++) begin
      drain_row[c*DATA_WIDTH +: DATA_WIDTH] = row_buf[drain_sel][c];
    end
  end

  // Buffer storage: pixel write at col, zero-fill of the tail on a padded row.
  always_ff @(posedge clk) begin
    for (int c = 0; c < IMAGE_SIZE; c++) begin
      if (accept && (col == IDX_WIDTH'(c))) begin
        row_buf[fill_sel][c] <= pix_data;
      end else if (pad_row && (IDX_WIDTH'(c) >= col)) begin
        row_buf[fill_sel][c] <= '0;
      end
    end
  end

  // Fill/drain control; fill and drain never touch the same full bit at one edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      col         <= '0;
      row_cnt     <= '0;
      full        <= 2'b00;
      fill_sel    <= 1'b0;
      drain_sel   <= 1'b0;
      wr_en       <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      row_idx     <= '0;
      data_out    <= '0;
    end else begin
      if (accept) begin
        col <= col + 1'b1;
      end
      if (row_end) begin
        col            <= '0;
        full[fill_sel] <= 1'b1;
        fill_sel       <= ~fill_sel;
      end
      if (drain) begin
        data_out        <= drain_row;
        wr_en           <= 1'b1;
        row_idx         <= row_cnt;
        frame_start     <= (row_cnt == '0);
        frame_done      <= (row_cnt == LAST_IDX);
        full[drain_sel] <= 1'b0;
        drain_sel       <= ~drain_sel;
        row_cnt         <= (row_cnt == LAST_IDX) ? '0 : row_cnt + 1'b1;
      end else begin
        wr_en       <= 1'b0;
        frame_start <= 1'b0;
        frame_done  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_image_row_feeder.sv
// Directed bench for image_row_feeder: continuous stream, backpressure,
// gapped input, mid-row reset, frame wrap and the flush/pad behaviour.
module tb_image_row_feeder;

  logic         clk = 1'b0;
  logic         rst;
  logic         pix_valid;
  logic [15:0]  pix_data;
  logic         pix_ready;
  logic         flush;
  logic         bank_ready;
  logic         wr_en;
  logic [255:0] data_out;
  logic [3:0]   row_idx;
  logic         frame_start;
  logic         frame_done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int acc15_cyc;

  logic [255:0] q_data[$];
  logic [3:0]   q_idx[$];
  logic         q_fs[$];
  logic         q_fd[$];
  int           q_cyc[$];

  image_row_feeder dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .flush(flush), .bank_ready(bank_ready),
    .wr_en(wr_en), .data_out(data_out), .row_idx(row_idx),
    .frame_start(frame_start), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every emitted row away from the active edge.
  always @(negedge clk) begin
    if (wr_en) begin
      q_data.push_back(data_out);
      q_idx.push_back(row_idx);
      q_fs.push_back(frame_start);
      q_fd.push_back(frame_done);
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mk_row(input int base);
    logic [255:0] r;
    r = '0;
    for (int c = 0; c < 16; c++) r[c*16 +: 16] = 16'(base + c);
    return r;
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_q();
    q_data.delete();
    q_idx.delete();
    q_fs.delete();
    q_fd.delete();
    q_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pix_valid = 1'b0;
    flush = 1'b0;
    tick(1);
    rst = 1'b1;
    clear_q();
  endtask

  task automatic send(input int v);
    int n;
    n = 0;
    pix_valid = 1'b1;
    pix_data  = 16'(v);
    while (!pix_ready && n < 1000) begin
      tick(1);
      n++;
    end
    if (n >= 1000) chk("send_stall", {255'b0, pix_ready}, 256'd1);
    @(posedge clk);
    #1;
    if (v == 15) acc15_cyc = cyc;
    pix_valid = 1'b0;
  endtask

  initial begin
    logic [255:0] exp_row;
    logic [255:0] w;
    rst = 1'b0;
    pix_valid = 1'b0;
    pix_data = '0;
    flush = 1'b0;
    bank_ready = 1'b1;

    // Reset state
    tick(1);
    chk("rst_wr_en", {255'b0, wr_en}, 256'd0);
    chk("rst_pix_ready", {255'b0, pix_ready}, 256'd1);
    chk("rst_row_idx", {252'b0, row_idx}, 256'd0);
    chk("rst_data_out", data_out, 256'd0);
    chk("rst_fs_fd", {254'b0, frame_start, frame_done}, 256'd0);
    rst = 1'b1;
    clear_q();

    // 1: continuous stream of one frame
    do_reset();
    bank_ready = 1'b1;
    for (int v = 0; v < 256; v++) send(v);
    tick(5);
    chk("s1_rows", q_data.size(), 256'd16);
    for (int r = 0; r < 16 && r < q_data.size(); r++) begin
      chk($sformatf("s1_data_r%0d", r), q_data[r], mk_row(16 * r));
      chk($sformatf("s1_idx_r%0d", r), {252'b0, q_idx[r]}, 256'(r));
      chk($sformatf("s1_fs_r%0d", r), {255'b0, q_fs[r]}, {255'b0, r == 0});
      chk($sformatf("s1_fd_r%0d", r), {255'b0, q_fd[r]}, {255'b0, r == 15});
    end
    if (q_cyc.size() > 0) chk("s1_latency", 256'(q_cyc[0] - acc15_cyc), 256'd1);

    // 2: backpressure holds two rows, then releases them in order
    do_reset();
    bank_ready = 1'b0;
    for (int v = 0; v < 32; v++) send(v);
    pix_valid = 1'b1;
    pix_data  = 16'd32;
    tick(4);
    chk("s2_stalled_ready", {255'b0, pix_ready}, 256'd0);
    chk("s2_no_wr", q_data.size(), 256'd0);
    bank_ready = 1'b1;
    for (int v = 32; v < 48; v++) send(v);
    tick(5);
    chk("s2_rows", q_data.size(), 256'd3);
    for (int r = 0; r < 3 && r < q_data.size(); r++) begin
      chk($sformatf("s2_data_r%0d", r), q_data[r], mk_row(16 * r));
      chk($sformatf("s2_idx_r%0d", r), {252'b0, q_idx[r]}, 256'(r));
    end
    if (q_cyc.size() >= 2) chk("s2_back_to_back", 256'(q_cyc[1] - q_cyc[0]), 256'd1);

    // 3: gapped input, one pixel every other cycle
    do_reset();
    for (int v = 0; v < 32; v++) begin
      send(v);
      tick(1);
    end
    tick(5);
    chk("s3_rows", q_data.size(), 256'd2);
    for (int r = 0; r < 2 && r < q_data.size(); r++)
      chk($sformatf("s3_data_r%0d", r), q_data[r], mk_row(16 * r));
    if (q_cyc.size() >= 2) chk("s3_spacing", 256'(q_cyc[1] - q_cyc[0]), 256'd32);

    // 4: reset mid-row discards the partial row
    do_reset();
    for (int v = 0; v < 7; v++) send(v);
    do_reset();
    for (int v = 100; v < 116; v++) send(v);
    tick(5);
    chk("s4_rows", q_data.size(), 256'd1);
    if (q_data.size() > 0) begin
      w = q_data[0];
      chk("s4_elem0", {240'b0, w[15:0]}, 256'd100);
      chk("s4_elem15", {240'b0, w[255:240]}, 256'd115);
      chk("s4_idx", {252'b0, q_idx[0]}, 256'd0);
      chk("s4_fs", {255'b0, q_fs[0]}, 256'd1);
    end

    // 5: frame wrap after 16 rows
    do_reset();
    for (int v = 0; v < 272; v++) send(v);
    tick(5);
    chk("s5_rows", q_data.size(), 256'd17);
    if (q_data.size() >= 17) begin
      chk("s5_fd_r15", {255'b0, q_fd[15]}, 256'd1);
      chk("s5_idx_r16", {252'b0, q_idx[16]}, 256'd0);
      chk("s5_fs_r16", {255'b0, q_fs[16]}, 256'd1);
      chk("s5_fd_r16", {255'b0, q_fd[16]}, 256'd0);
      chk("s5_data_r16", q_data[16], mk_row(256));
    end

    // 6: flush of a 5-pixel partial row
    do_reset();
    for (int v = 1; v <= 5; v++) send(v);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(5);
`ifdef FEEDER_PAD_EN
    exp_row = '0;
    for (int c = 0; c < 5; c++) exp_row[c*16 +: 16] = 16'(c + 1);
    chk("s6_rows", q_data.size(), 256'd1);
    if (q_data.size() > 0) chk("s6_padded_row", q_data[0], exp_row);
`else
    exp_row = '0;
    chk("s6_rows", q_data.size(), 256'd0);
    chk("s6_ready", {255'b0, pix_ready}, {255'b0, exp_row[0] == 1'b0});
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
